trace_issue_queue: RTL and testbench

TRACE_ISSUE_QUEUE -- requirements
Module: trace_issue_queue

---
 rtl/trace_issue_queue.sv | 136 +++++++++++++
 tb/tb_trace_issue_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_issue_queue.sv
// trace_issue_queue: FIFO of parsed trace entries. The head entry is offered
// to the scheduler once the simulated CPU clock reaches its issue time.
// The CPU clock can jump forward to the first entry's time while idle.
module trace_issue_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SKIP_IDLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_time,
    input  logic [1:0]             in_op,
    input  logic [31:0]            in_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_time,
    output logic [1:0]             out_op,
    output logic [31:0]            out_addr,
    output logic [31:0]            cpu_clock,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   order_err,
    output logic                   op_err
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [1:0]  OP_ILLEGAL = 2'd3;

    logic [31:0]   time_mem [DEPTH];
    logic [1:0]    op_mem   [DEPTH];
    logic [31:0]   addr_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   cpu_clock_q, cpu_clock_d;
    logic [31:0]   last_time_q, last_time_d;
    logic          order_err_q, order_err_d;
    logic          op_err_q, op_err_d;

    logic          push;
    logic          store;
    logic          pop;
    logic [32:0]   next_tick;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign count     = count_q;
    assign cpu_clock = cpu_clock_q;
    assign order_err = order_err_q;
    assign op_err    = op_err_q;

    assign out_valid = !empty && (cpu_clock_q >= time_mem[rptr_q]);
    assign out_time  = empty ? '0 : time_mem[rptr_q];
    assign out_op    = empty ? '0 : op_mem[rptr_q];
    assign out_addr  = empty ? '0 : addr_mem[rptr_q];

    // Handshakes: illegal ops complete the input handshake but are dropped.
    assign push  = in_valid && in_ready;
    assign store = push && (in_op != OP_ILLEGAL);
    assign pop   = out_valid && out_ready;

    // Next-state: pointers, occupancy, CPU time and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        cpu_clock_d = cpu_clock_q;
        last_time_d = last_time_q;
        order_err_d = order_err_q;
        op_err_d    = op_err_q;
        next_tick   = {1'b0, cpu_clock_q} + 33'd1;

        if (store) begin
            wptr_d      = wptr_q + AW'(1);
            last_time_d = in_time;
            if (in_time < last_time_q) begin
                order_err_d = 1'b1;
            end
        end
        if (push && (in_op == OP_ILLEGAL)) begin
            op_err_d = 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // 33-bit compare so cpu_clock+1 cannot wrap at the top of the range.
        if ((SKIP_IDLE != 0) && empty && store && ({1'b0, in_time} > next_tick)) begin
            cpu_clock_d = in_time;
        end else if (cpu_clock_q != '1) begin
            cpu_clock_d = next_tick[31:0];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            cpu_clock_q <= '0;
            last_time_q <= '0;
            order_err_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            cpu_clock_q <= cpu_clock_d;
            last_time_q <= last_time_d;
            order_err_q <= order_err_d;
            op_err_q    <= op_err_d;
        end
    end

    // Entry storage; contents are don't-care until referenced by a valid pointer.
    always_ff @(posedge clk) begin
        if (store) begin
            time_mem[wptr_q] <= in_time;
            op_mem[wptr_q]   <= in_op;
            addr_mem[wptr_q] <= in_addr;
        end
    end

endmodule

// File: tb/tb_trace_issue_queue.sv
// tb_trace_issue_queue: randomized plus directed stimulus against a
// queue-based reference model; a negedge monitor compares DUT outputs.
module tb_trace_issue_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_time = '0;
    logic [1:0]    in_op = '0;
    logic [31:0]   in_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_time;
    logic [1:0]    out_op;
    logic [31:0]   out_addr;
    logic [31:0]   cpu_clock;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          order_err;
    logic          op_err;

    always #5 clk = ~clk;

    trace_issue_queue #(.DEPTH(DEPTH), .SKIP_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_time(out_time), .out_op(out_op), .out_addr(out_addr),
        .cpu_clock(cpu_clock), .count(count), .full(full), .empty(empty),
        .order_err(order_err), .op_err(op_err)
    );

    // Reference model: plain queue of accepted entries plus CPU time.
    typedef struct {
        logic [31:0] t;
        logic [1:0]  op;
        logic [31:0] a;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_clk   = '0;
    logic [31:0] m_last  = '0;
    logic        m_oerr  = 1'b0;
    logic        m_operr = 1'b0;
    logic        m_push, m_pop, m_legal;
    ent_t        m_ent;
    logic        tmo = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model update at each edge, cleared asynchronously like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_clk   = '0;
            m_last  = '0;
            m_oerr  = 1'b0;
            m_operr = 1'b0;
        end else begin
            m_push  = in_valid && (mq.size() < DEPTH);
            m_pop   = out_ready && (mq.size() != 0) && (m_clk >= mq[0].t);
            m_legal = (in_op != 2'd3);
            if (mq.size() == 0 && m_push && m_legal &&
                longint'(in_time) > longint'(m_clk) + 64'sd1)
                m_clk = in_time;
            else if (m_clk != 32'hFFFF_FFFF)
                m_clk = m_clk + 32'd1;
            if (m_pop) void'(mq.pop_front());
            if (m_push && m_legal) begin
                if (in_time < m_last) m_oerr = 1'b1;
                m_last  = in_time;
                m_ent.t  = in_time;
                m_ent.op = in_op;
                m_ent.a  = in_addr;
                mq.push_back(m_ent);
            end
            if (m_push && !m_legal) m_operr = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT state and offered head entry against the model.
    always @(negedge clk) begin
        chk("cpu_clock", cpu_clock, m_clk);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0 && m_clk >= mq[0].t));
        if (mq.size() != 0) begin
            chk("out_time", out_time, mq[0].t);
            chk("out_op", 32'(out_op), 32'(mq[0].op));
            chk("out_addr", out_addr, mq[0].a);
        end else begin
            chk("out_time_empty", out_time, 32'h0);
            chk("out_op_empty", 32'(out_op), 32'h0);
            chk("out_addr_empty", out_addr, 32'h0);
        end
        chk("order_err", 32'(order_err), 32'(m_oerr));
        chk("op_err", 32'(op_err), 32'(m_operr));
        chk("drain_timeout", 32'(tmo), 32'h0);
    end

    // Drive one cycle's inputs, then step to just after the next edge.
    task automatic cyc(input logic v, input logic [31:0] t, input logic [1:0] op,
                       input logic [31:0] a, input logic rdy);
        in_valid  = v;
        in_time   = t;
        in_op     = op;
        in_addr   = a;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 2'd0, 32'h0, rdy);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (mq.size() != 0 && n < budget) begin
            idle(1'b1);
            n++;
        end
        if (mq.size() != 0) tmo = 1'b1;
    endtask

    task automatic wait_clk3();
        for (int i = 0; i < 10 && m_clk != 32'd3; i++) idle(1'b0);
        if (m_clk != 32'd3) tmo = 1'b1;
    endtask

    // Reset lands mid-cycle while a push and pop are being offered.
    task automatic mid_reset();
        in_valid  = 1'b1;
        in_time   = 32'd7;
        in_op     = 2'd0;
        in_addr   = 32'h7777;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [31:0] base;
    logic [31:0] t;
    logic [1:0]  op;

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle fast-forward from cpu_clock 3 to 500.
        wait_clk3();
        cyc(1'b1, 32'd500, 2'd1, 32'h000B_EEF0, 1'b0);
        idle(1'b0);
        drain(10);

        // Fill to full with due entries, 17th offer ignored.
        for (int i = 0; i < 17; i++) cyc(1'b1, 32'd0, 2'(i % 3), 32'h100 + 32'(i), 1'b0);
        // Offer and take together; push only lands once in_ready returns.
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'd0, 2'd2, 32'h200 + 32'(i), 1'b1);
        drain(40);

        // Out-of-order times are kept in arrival order.
        base = m_clk;
        cyc(1'b1, base + 32'd40, 2'd0, 32'h4040, 1'b0);
        cyc(1'b1, base + 32'd20, 2'd1, 32'h2020, 1'b0);
        drain(100);

        // Illegal op consumed but not stored.
        cyc(1'b1, 32'd0, 2'd3, 32'hDEAD, 1'b0);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       t = m_clk + 32'($urandom_range(50, 300));
                1:       t = (m_clk >= 32'd3) ? m_clk - 32'd3 : 32'd0;
                default: t = m_clk + 32'($urandom_range(0, 12));
            endcase
            if (op == 2'd3) t = 32'd0;
            cyc(1'($urandom_range(0, 2) != 0), t, op, $urandom, 1'($urandom_range(0, 3) != 0));
        end
        drain(400);

        // Reset mid-operation with 5 queued entries, then behave as fresh.
        base = m_clk;
        for (int i = 0; i < 5; i++) cyc(1'b1, base + 32'd1000, 2'd0, 32'h500 + 32'(i), 1'b0);
        mid_reset();
        wait_clk3();
        cyc(1'b1, 32'd500, 2'd1, 32'h000B_EEF0, 1'b0);
        idle(1'b0);
        drain(10);

        // Saturation at the top of the time range.
        cyc(1'b1, 32'hFFFF_FFF0, 2'd2, 32'hF0F0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFF, 2'd0, 32'hFFFF, 1'b0);
        repeat (20) idle(1'b0);
        drain(10);
        repeat (2) idle(1'b0);

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
